view_control: RTL and testbench

Sequencing FSM that drives the `view` pixel datapath and generates the VGA adapter write strobe. On a frame request it sweeps the full background, then accepts sprite descriptors (gold or stone) over a valid/ready handshake. For each descriptor it loads the datapath origin and steps the 16x16 sprite counter. It sits between game logic (object producer) and `view`, and owns the plot/clipping decisions that the datapath does not make.

---
 rtl/view_control_if.sv | 22 ++
 rtl/view_control.sv | 168 ++++++++++++++++
 tb/tb_view_control.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/view_control_if.sv
// Sprite descriptor valid/ready channel.
// Game logic drives the master side; view_control is the slave.
interface view_control_if;
  logic       obj_valid;
  logic       obj_ready;
  logic [8:0] obj_x;
  logic [7:0] obj_y;
  logic       obj_is_stone;
  logic       obj_last;

  modport master (
    output obj_valid, obj_x, obj_y,
    output obj_is_stone, obj_last,
    input  obj_ready
  );

  modport slave (
    input  obj_valid, obj_x, obj_y,
    input  obj_is_stone, obj_last,
    output obj_ready
  );
endinterface

// File: rtl/view_control.sv
// Frame sequencer for the view datapath: background sweep,
// then sprite descriptors, with a clipped, pipelined plot strobe.
module view_control #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       draw_objects,
  view_control_if.slave obj,
  output logic [8:0] x_init,
  output logic [7:0] y_init,
  output logic       load_x,
  output logic       load_y,
  output logic       load_stone,
  output logic       load_color,
  output logic       resetn_c,
  output logic       enable_c,
  output logic       enable_x_adder,
  output logic       enable_y_adder,
  output logic       draw_background,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] BG_DRAW   = 3'd1;
  localparam logic [2:0] BG_FLUSH  = 3'd2;
  localparam logic [2:0] OBJ_WAIT  = 3'd3;
  localparam logic [2:0] OBJ_LOAD  = 3'd4;
  localparam logic [2:0] OBJ_DRAW  = 3'd5;
  localparam logic [2:0] OBJ_FLUSH = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  localparam logic [9:0]  W_LIM  = 10'(SCREEN_W);
  localparam logic [8:0]  H_LIM  = 9'(SCREEN_H);
  localparam logic [16:0] FL_END = 17'(PIPE_LAT - 1);

  logic [2:0]          state_q, state_d;
  logic [16:0]         cnt_q, cnt_d;
  logic                objs_q, objs_d;
  logic                stone_q, stone_d;
  logic                last_q, last_d;
  logic                rdy_q;
  logic [8:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [PIPE_LAT-1:0] pipe_q;
  logic [PIPE_LAT:0]   shift;
  logic                xfer, issue, bg_v, obj_v;
  logic [9:0]          sx;
  logic [8:0]          sy;

  assign xfer = (state_q == OBJ_WAIT) && obj.obj_valid && rdy_q;

  // cnt_q doubles as the view background counter mirror
  assign bg_v = ({1'b0, cnt_q[8:0]} < W_LIM) &&
                ({1'b0, cnt_q[16:9]} < H_LIM);
  assign sx = {1'b0, x_q} + {6'b0, cnt_q[3:0]};
  assign sy = {1'b0, y_q} + {5'b0, cnt_q[7:4]};
  assign obj_v = (sx < W_LIM) && (sy < H_LIM);

  assign issue = ((state_q == BG_DRAW) && bg_v) ||
                 ((state_q == OBJ_DRAW) && obj_v);
  assign shift = {pipe_q, issue};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    objs_d  = objs_q;
    stone_d = stone_q;
    last_d  = last_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = BG_DRAW;
        cnt_d   = '0;
        objs_d  = draw_objects;
      end
      BG_DRAW: begin
        cnt_d = cnt_q + 17'd1;
        if (cnt_q == 17'h1FFFF) state_d = BG_FLUSH;
      end
      BG_FLUSH: begin
        cnt_d = cnt_q + 17'd1;
        if (cnt_q == FL_END) begin
          cnt_d   = '0;
          state_d = objs_q ? OBJ_WAIT : DONE;
        end
      end
      OBJ_WAIT: if (xfer) begin
        state_d = OBJ_LOAD;
        x_d     = obj.obj_x;
        y_d     = obj.obj_y;
        stone_d = obj.obj_is_stone;
        last_d  = obj.obj_last;
      end
      OBJ_LOAD: begin
        state_d = OBJ_DRAW;
        cnt_d   = '0;
      end
      OBJ_DRAW: begin
        cnt_d = cnt_q + 17'd1;
        if (cnt_q[7:0] == 8'hFF) begin
          cnt_d   = '0;
          state_d = OBJ_FLUSH;
        end
      end
      OBJ_FLUSH: begin
        cnt_d = cnt_q + 17'd1;
        if (cnt_q == FL_END) begin
          cnt_d   = '0;
          state_d = last_q ? DONE : OBJ_WAIT;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      objs_q  <= 1'b0;
      stone_q <= 1'b0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      objs_q  <= objs_d;
      stone_q <= stone_d;
      last_q  <= last_d;
      rdy_q   <= (state_d == OBJ_WAIT);
      x_q     <= x_d;
      y_q     <= y_d;
      pipe_q  <= shift[PIPE_LAT-1:0];
    end
  end

  assign obj.obj_ready   = rdy_q;
  assign x_init          = x_q;
  assign y_init          = y_q;
  assign load_x          = (state_q == OBJ_LOAD);
  assign load_y          = (state_q == OBJ_LOAD);
  assign resetn_c        = (state_q != OBJ_LOAD);
  assign load_stone      = stone_q &&
                           ((state_q == OBJ_LOAD) ||
                            (state_q == OBJ_DRAW) ||
                            (state_q == OBJ_FLUSH));
  assign enable_c        = (state_q == OBJ_DRAW);
  assign draw_background = (state_q == BG_DRAW);
  assign load_color      = (state_q == BG_DRAW) ||
                           (state_q == OBJ_DRAW);
  assign enable_x_adder  = load_color;
  assign enable_y_adder  = load_color;
  assign plot            = pipe_q[PIPE_LAT-1];
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_view_control.sv
// Directed bench for view_control: reset, background sweep,
// sprite handshakes, clipping and ignored start pulses.
module tb_view_control;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       draw_objects = 1'b0;
  logic [8:0] x_init;
  logic [7:0] y_init;
  logic load_x, load_y, load_stone, load_color;
  logic resetn_c, enable_c, enable_x_adder;
  logic enable_y_adder, draw_background;
  logic plot, busy, done;

  view_control_if oif ();

  view_control dut (
    .clk(clk), .resetn(resetn),
    .start(start), .draw_objects(draw_objects),
    .obj(oif),
    .x_init(x_init), .y_init(y_init),
    .load_x(load_x), .load_y(load_y),
    .load_stone(load_stone), .load_color(load_color),
    .resetn_c(resetn_c), .enable_c(enable_c),
    .enable_x_adder(enable_x_adder),
    .enable_y_adder(enable_y_adder),
    .draw_background(draw_background),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_plot = 0, n_bg = 0, n_done = 0;
  int n_load = 0, n_enc = 0, n_xfer = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (plot) n_plot <= n_plot + 1;
    if (draw_background) n_bg <= n_bg + 1;
    if (done) n_done <= n_done + 1;
    if (load_x) n_load <= n_load + 1;
    if (enable_c) n_enc <= n_enc + 1;
    if (oif.obj_valid && oif.obj_ready)
      n_xfer <= n_xfer + 1;
  end

  task automatic chk(input string tag, input int obs,
                     input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rdy"}, int'(oif.obj_ready), 0);
    chk({tag, "_xy"}, int'({x_init, y_init}), 0);
    chk({tag, "_rc"}, int'(resetn_c), 1);
    chk({tag, "_en"}, int'({load_x, load_y, load_stone,
        load_color, enable_c, enable_x_adder,
        enable_y_adder, draw_background}), 0);
  endtask

  task automatic sprite(input int x, input int y,
                        input bit stone, input bit last,
                        input int gap, input bit hold,
                        input int ep, input string tag);
    int k, sp, se, t1;
    repeat (gap) @(negedge clk);
    oif.obj_x = 9'(x);
    oif.obj_y = 8'(y);
    oif.obj_is_stone = stone;
    oif.obj_last = last;
    oif.obj_valid = 1'b1;
    k = 0;
    while (!oif.obj_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_rdy_to"}, int'(k < 1000), 1);
    sp = n_plot;
    se = n_enc;
    @(negedge clk);
    oif.obj_valid = hold;
    chk({tag, "_loadx"}, int'(load_x & load_y), 1);
    chk({tag, "_rc"}, int'(resetn_c), 0);
    chk({tag, "_xi"}, int'(x_init), x);
    chk({tag, "_yi"}, int'(y_init), y);
    chk({tag, "_stone"}, int'(load_stone), int'(stone));
    t1 = cyc;
    k = 0;
    while (!(oif.obj_ready || done) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_plots"}, n_plot - sp, ep);
    chk({tag, "_enc"}, n_enc - se, 256);
    chk({tag, "_lat"}, cyc - t1, 259);
    chk({tag, "_done"}, int'(done), int'(last));
  endtask

  initial begin
    int k, c0, p0, b0, d0, l0, x0;
    oif.obj_valid = 1'b0;
    oif.obj_x = '0;
    oif.obj_y = '0;
    oif.obj_is_stone = 1'b0;
    oif.obj_last = 1'b0;
    #1;
    reset_vals("por");
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    @(negedge clk);
    start = 1'b1;
    draw_objects = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("r_bg_on", int'(draw_background), 1);
    repeat (500) @(negedge clk);
    resetn = 1'b0;
    #1;
    reset_vals("midrst");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("r_idle", int'(busy), 0);

    c0 = cyc;
    p0 = n_plot;
    b0 = n_bg;
    d0 = n_done;
    l0 = n_load;
    x0 = n_xfer;
    start = 1'b1;
    draw_objects = 1'b1;
    @(negedge clk);
    start = 1'b0;
    draw_objects = 1'b0;
    chk("bg_first", cyc - c0, 1);
    chk("bg_on", int'(draw_background), 1);
    chk("bg_busy", int'(busy), 1);
    repeat (1000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!oif.obj_ready && k < 140000) begin
      @(negedge clk);
      k++;
    end
    chk("bg_to", int'(k < 140000), 1);
    chk("bg_end", cyc - c0, 131075);
    chk("bg_cycles", n_bg - b0, 131072);
    chk("bg_plots", n_plot - p0, 76800);

    sprite(100, 50, 1'b0, 1'b0, 0, 1'b0, 256, "gold");
    sprite(310, 230, 1'b1, 1'b0, 0, 1'b1, 100, "clip");
    sprite(0, 0, 1'b1, 1'b0, 0, 1'b0, 256, "s0");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sprite(315, 100, 1'b0, 1'b0, 5, 1'b0, 80, "s1");
    sprite(200, 235, 1'b1, 1'b1, 20, 1'b0, 80, "s2");

    @(negedge clk);
    chk("end_busy", int'(busy), 0);
    chk("end_done", int'(done), 0);
    chk("n_done", n_done - d0, 1);
    chk("n_load", n_load - l0, 5);
    chk("n_xfer", n_xfer - x0, 5);
    repeat (10) @(negedge clk);
    chk("no_queue", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
